alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction issue controller that drives the 4-stage register-bank/ALU/memory pipeline from the instruction-producer side. It accepts packed instruction words over a valid/ready handshake and buffers them in a small FIFO. It issues them in order as rs1/rs2/rd/func/addr with a one-cycle issue strobe. A per-register busy scoreboard inserts bubbles so an instruction never reads a register whose write-back is still in flight.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- HAZARD_GAP, 3, cycles a destination register stays busy after issue; range 1..7
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has an instruction on in_instr
- in_ready  out  1  FIFO can accept; combinational, equals (fifo_count < DEPTH)
- in_instr  in  24  [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
- hold  in  1  downstream stall; no issue while high
- rs1, rs2, rd, func  out  4 each  issued fields, registered
- addr  out  8  issued memory write address, registered
- issue_valid  out  1  high for exactly one cycle per issued instruction
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- issue_cnt  out  16  instructions issued, saturating at 16'hFFFF
- stall_cnt  out  16  hazard-stall cycles, saturating at 16'hFFFF

## Operation
- Push: when in_valid && in_ready, in_instr is written at the tail. When full, in_ready stays low even if a pop happens in the same cycle. No same-cycle fall-through.
- Head is issuable when the FIFO is non-empty, hold is low, and no hazard exists.
- Hazard: busy[rs1] != 0 for funcs 0,1,2,3,5,6,7,8,10,11; busy[rs2] != 0 for funcs 0,1,2,4,5,6,7,9. Funcs 12..15 check both operands.
- On issue: output registers load the head fields, issue_valid=1, head pops, busy[rd] <= HAZARD_GAP, and issue_cnt increments.
- Every cycle, each non-zero busy entry decrements by 1. If a decrement and a set hit the same register in the same cycle, the set wins.
- No issue: rs1/rs2/rd/func/addr hold their last values and issue_valid=0.
- stall_cnt increments in every cycle where the FIFO is non-empty, hold is low, and a hazard blocks the head. Cycles blocked by hold are not counted.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- Reset, including mid-operation: FIFO emptied, all busy entries 0, all outputs and counters 0, issue_valid 0. in_ready reads 1 while reset is asserted.

## Timing
- Instruction accepted at edge N can issue at edge N+1 at the earliest; issued fields are valid after that edge.
- Throughput: one issue per cycle with no hazards and hold low.
- Producer issued at edge P with rd=R: a dependent reader of R issues no earlier than edge P+HAZARD_GAP+1, which means HAZARD_GAP bubbles.
- hold sampled at edge E suppresses the issue at E. Issue resumes at the first edge with hold low.

## Configuration
- ISSUE_SCOREBOARD_EN defined: busy table, hazard checks, and stall_cnt behave as described above.
- ISSUE_SCOREBOARD_EN undefined: no busy table and no hazard stalls. The head issues whenever the FIFO is non-empty and hold is low. stall_cnt is tied to 0.

## Test plan
- Reset mid-stream with 3 entries queued and busy[2]=2: assert rst_n low, release. Required: fifo_count=0, issue_valid=0, all outputs 0, in_ready=1, and a new instruction reading r2 issues one cycle after it is accepted.
- Four independent instructions pushed back-to-back (rd=1..4, rs=8/9): issue on four consecutive edges, issue_cnt=4, stall_cnt=0.
- ADD r1<=r2+r3 followed by SUB r4<=r1-r5, HAZARD_GAP=3: SUB issues 4 edges after ADD, with 3 bubble cycles and stall_cnt=3.
- SELB (func 4) r6<=r1, immediately after a write to r1 from a func-0 instruction (rs1=r1 field present): this is a true dependency on the rs2 operand, so it stalls HAZARD_GAP cycles. A func-3 instruction with rs2=r1 does not stall.
- Fill with hold=1: after DEPTH pushes, in_ready=0 and extra in_valid pulses are dropped. Release hold: the FIFO drains in order, and in_ready rises the cycle after the first pop.
- Build with ISSUE_SCOREBOARD_EN undefined: the dependent ADD/SUB pair issues on consecutive edges, and stall_cnt stays 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered in-order instruction issue for the ALU pipeline.
// Define ISSUE_SCOREBOARD_EN to enable the per-register busy scoreboard and hazard stalls.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HAZARD_GAP = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_instr,
    input  logic                     hold,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [3:0]               rd,
    output logic [3:0]               func,
    output logic [7:0]               addr,
    output logic                     issue_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issue_cnt,
    output logic [15:0]              stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, func_q, func_d;
    logic [7:0]    addr_q, addr_d;
    logic          issue_valid_q, issue_valid_d;
    logic [15:0]   issue_cnt_q, issue_cnt_d;

    logic [23:0]   head;
    logic          push, pop, empty, hazard;

    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign in_ready = (count_q < FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !hold && !hazard;

`ifdef ISSUE_SCOREBOARD_EN
    localparam logic [2:0] GAP3 = 3'(HAZARD_GAP);

    logic [2:0]  busy_q [16];
    logic [2:0]  busy_d [16];
    logic        use_rs1, use_rs2;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (head[23:20])
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7,
            4'd12, 4'd13, 4'd14, 4'd15: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            4'd3, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
            4'd4, 4'd9:               use_rs2 = 1'b1;
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    assign hazard = (use_rs1 && (busy_q[head[15:12]] != 3'd0)) ||
                    (use_rs2 && (busy_q[head[11:8]]  != 3'd0));

    // Decrement first, then let a same-cycle issue overwrite its rd entry.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            busy_d[i] = (busy_q[i] != 3'd0) ? (busy_q[i] - 3'd1) : 3'd0;
        end
        if (pop) begin
            busy_d[head[19:16]] = GAP3;
        end
        stall_cnt_d = stall_cnt_q;
        if (!empty && !hold && hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                busy_q[i] <= 3'd0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                busy_q[i] <= busy_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic gap_unused;
    assign gap_unused = (HAZARD_GAP != 0);
    assign hazard     = 1'b0;
    assign stall_cnt  = '0;
`endif

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        func_d        = func_q;
        addr_d        = addr_q;
        issue_cnt_d   = issue_cnt_q;
        issue_valid_d = pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            func_d   = head[23:20];
            rd_d     = head[19:16];
            rs1_d    = head[15:12];
            rs2_d    = head[11:8];
            addr_d   = head[7:0];
            if (issue_cnt_q != 16'hFFFF) begin
                issue_cnt_d = issue_cnt_q + 16'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            func_q        <= '0;
            addr_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_cnt_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            func_q        <= func_d;
            addr_q        <= addr_d;
            issue_valid_q <= issue_valid_d;
            issue_cnt_q   <= issue_cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign func        = func_q;
    assign addr        = addr_q;
    assign issue_valid = issue_valid_q;
    assign fifo_count  = count_q;
    assign issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus queues expected issues with their
// issue edge; a negedge monitor pops and compares every issued instruction.
module tb_alu_issue_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HG    = 3;
`ifdef ISSUE_SCOREBOARD_EN
    localparam int ST = HG;
`else
    localparam int ST = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic        hold;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic [2:0]  fifo_count;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    alu_issue_ctrl #(.DEPTH(DEPTH), .HAZARD_GAP(HG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .hold        (hold),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .issue_valid (issue_valid),
        .fifo_count  (fifo_count),
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] ins;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mk(input int f, input int d, input int a1, input int a2, input int ad);
        return {4'(f), 4'(d), 4'(a1), 4'(a2), 8'(ad)};
    endfunction

    // Called at a negedge; dly is edges from acceptance to issue, negative means never issues.
    task automatic push(input logic [23:0] ins, input int dly);
        exp_t e;
        in_valid = 1'b1;
        in_instr = ins;
        if (dly >= 0) begin
            e.ins = ins;
            e.at  = cyc + 1 + dly;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue: got %0h want none (cyc=%0d)",
                         {func, rd, rs1, rs2, addr}, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("issue_fields", 32'({func, rd, rs1, rs2, addr}), 32'(mon_e.ins));
                chk("issue_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        in_instr = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_fields", 32'({func, rd, rs1, rs2, addr}), 32'd0);
        chk("rst_cnts", {issue_cnt, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mid-stream reset: X issues, three entries queued, busy[2]=2.
        hold = 1'b1;
        push(mk(0, 2, 8, 9, 'h11), 2);
        push(mk(0, 5, 2, 2, 'h12), -1);
        hold = 1'b0;
        push(mk(1, 6, 2, 3, 'h13), -1);
        hold = 1'b1;
        push(mk(2, 7, 2, 2, 'h14), -1);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_issue_cnt", 32'(issue_cnt), 32'd1);
        rst_n = 1'b0;
        hold  = 1'b0;
        #1;
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_valid", 32'(issue_valid), 32'd0);
        chk("mid_rst_fields", 32'({func, rd, rs1, rs2, addr}), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnts", {issue_cnt, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(mk(0, 5, 2, 2, 'h21), 1);
        idle(6);
        chk("s1_issue_cnt", 32'(issue_cnt), 32'd1);
        chk("s1_stall_cnt", 32'(stall_cnt), 32'd0);

        // Four independent instructions back-to-back.
        for (int i = 0; i < 4; i++) begin
            push(mk(0, i + 1, 8, 9, 'h30 + i), 1);
        end
        idle(6);
        chk("s2_issue_cnt", 32'(issue_cnt), 32'd5);
        chk("s2_stall_cnt", 32'(stall_cnt), 32'd0);

        // ADD r1<=r2+r3 then SUB r4<=r1-r5.
        push(mk(0, 1, 2, 3, 'h40), 1);
        push(mk(1, 4, 1, 5, 'h41), 1 + ST);
        idle(8);
        chk("s3_issue_cnt", 32'(issue_cnt), 32'd7);
        chk("s3_stall_cnt", 32'(stall_cnt), 32'(ST));

        // SELB reads r1 through rs2: true dependency.
        push(mk(0, 1, 2, 3, 'h50), 1);
        push(mk(4, 6, 1, 1, 'h51), 1 + ST);
        idle(8);
        chk("s4a_issue_cnt", 32'(issue_cnt), 32'd9);
        chk("s4a_stall_cnt", 32'(stall_cnt), 32'(2 * ST));

        // func 3 ignores rs2, so rs2=r1 must not stall.
        push(mk(0, 1, 2, 3, 'h60), 1);
        push(mk(3, 7, 9, 1, 'h61), 1);
        idle(6);
        chk("s4b_issue_cnt", 32'(issue_cnt), 32'd11);
        chk("s4b_stall_cnt", 32'(stall_cnt), 32'(2 * ST));

        // Fill under hold, drop extras, then drain in order.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(mk(2, 10 + i, 14, 15, 'h70 + i), 6);
        end
        chk("s5_full_ready", 32'(in_ready), 32'd0);
        chk("s5_full_count", 32'(fifo_count), 32'd4);
        in_valid = 1'b1;
        in_instr = mk(0, 0, 0, 0, 'hEE);
        idle(2);
        in_valid = 1'b0;
        chk("s5_drop_count", 32'(fifo_count), 32'd4);
        hold = 1'b0;
        chk("s5_ready_before_pop", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("s5_ready_after_pop", 32'(in_ready), 32'd1);
        chk("s5_count_after_pop", 32'(fifo_count), 32'd3);
        idle(8);
        chk("s5_issue_cnt", 32'(issue_cnt), 32'd15);
        chk("s5_stall_cnt", 32'(stall_cnt), 32'(2 * ST));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
